muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately, independent of clk.
REQ-003 SHALL have port start  input  1  request from the execute stage; M-extension instruction present in ID/EX.
REQ-004 SHALL have port flush  input  1  kill in-flight operation (branch/jump redirect).
REQ-005 SHALL have port funct3E  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port rdata1E  input  32  operand A (rs1).
REQ-007 SHALL have port rdata2E  input  32  operand B (rs2).
REQ-008 SHALL have port stall  output  1  freeze fetch, decode and ID/EX while asserted.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-011 SHALL have port result  output  32  op result; held until the next accepted start.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 IDLE: start=1 and flush=0 at an edge SHALL accept the op and latch funct3E, rdata1E, rdata2E.
- Accepted special case -> DONE.
- Otherwise -> CALC with iteration counter = 0.
REQ-014 CALC SHALL perform one radix-2 step per cycle, 32 steps (counter 0..31).
- Multiply: shift-add into a 64-bit product.
- Divide: restoring shift-subtract into a 32-bit quotient and a 33-bit partial remainder.
REQ-015 CALC with counter=31 SHALL go to DONE at the next edge.
REQ-016 DONE SHALL assert done=1 and update result for exactly one cycle, then return to IDLE.
REQ-017 A start in DONE SHALL be ignored; start is sampled only in IDLE.
REQ-018 Iterative latency: start accepted at edge k -> done=1 in the cycle following edge k+32.
REQ-019 Special-case latency: done=1 in the cycle following edge k.
REQ-020 stall SHALL equal (IDLE & start & !flush) | CALC, combinationally.
- stall=0 in DONE, so the pipeline advances on the edge ending DONE.
REQ-021 Signed operands (MULH/MULHSU A, DIV/REM both) SHALL be converted to magnitude at acceptance; the final sign SHALL be applied in DONE.
REQ-022 Result mapping:
- MUL = product[31:0].
- MULH/MULHSU/MULHU = product[63:32] of the signed-signed, signed-unsigned and unsigned-unsigned product respectively.
- DIV/DIVU = quotient; REM/REMU = remainder.
- Remainder sign follows the dividend; quotient sign = sign(A) XOR sign(B).
REQ-023 Divide by zero (B=0) SHALL be a special case:
- DIV/DIVU -> 32'hFFFFFFFF.
- REM/REMU -> A.
REQ-024 Signed overflow (DIV/REM, A=32'h80000000, B=32'hFFFFFFFF) SHALL be a special case: DIV -> 32'h80000000, REM -> 0.
REQ-025 flush=1 in CALC or DONE SHALL force IDLE at the next edge.
- done SHALL be 0 in that cycle; result SHALL be unchanged.
REQ-026 flush and start both high in IDLE: flush SHALL win; no op is accepted.
REQ-027 Operand inputs changing during CALC SHALL have no effect on the result.

Reset
REQ-028 rst=0 SHALL asynchronously set state=IDLE, counter=0, internal product/quotient/remainder=0, result=0, done=0, busy=0.
REQ-029 stall SHALL be 0 while rst=0, regardless of start.
REQ-030 rst asserted mid-CALC SHALL abort the op with no done pulse.
- After release, the first start SHALL complete normally.
REQ-031 Release of rst SHALL take effect only at a rising clk edge; no op is accepted in the release cycle unless start is high at that edge.

Verification
REQ-032 MUL A=7, B=-3 (32'hFFFFFFFD) -> result=32'hFFFFFFEB; done exactly 33 cycles after the acceptance edge; stall high for 33 cycles.
REQ-033 MULHU A=B=32'hFFFFFFFF -> result=32'hFFFFFFFE; MULH with the same operands -> 0.
REQ-034 DIV A=-7, B=2 -> 32'hFFFFFFFD; REM with the same operands -> 32'hFFFFFFFF; DIVU A=100, B=7 -> 14; REMU -> 2.
REQ-035 Special cases finish one cycle after acceptance:
- DIVU A=5, B=0 -> 32'hFFFFFFFF; REM A=5, B=0 -> 5.
- DIV A=32'h80000000, B=-1 -> 32'h80000000.
REQ-036 Aborts:
- flush at CALC counter=10 -> IDLE next edge, no done, result keeps its prior value.
- rst=0 mid-CALC -> busy=0 immediately.
- A new start afterwards completes with correct result.
REQ-037 Back-to-back: start held high -> a second op is accepted only on the edge leaving DONE's following IDLE cycle, and both results are correct.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, with one-cycle divide-by-zero and overflow shortcuts.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic [2:0]  funct3E,
  input  logic [31:0] rdata1E,
  input  logic [31:0] rdata2E,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] quo_q, quo_d;
  logic [32:0] rem_q, rem_d;
  logic        neg_q, neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic        special_q, special_d;
  logic [31:0] spec_res_q, spec_res_d;
  logic [31:0] result_q, result_d;

  // Operand decode at acceptance
  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        div_zero, div_ovf;
  logic [31:0] spec_val;

  assign a_signed = (funct3E == 3'b001) || (funct3E == 3'b010) ||
                    (funct3E == 3'b100) || (funct3E == 3'b110);
  assign b_signed = (funct3E == 3'b001) || (funct3E == 3'b100) || (funct3E == 3'b110);
  assign a_neg    = a_signed & rdata1E[31];
  assign b_neg    = b_signed & rdata2E[31];
  assign a_mag    = a_neg ? (32'd0 - rdata1E) : rdata1E;
  assign b_mag    = b_neg ? (32'd0 - rdata2E) : rdata2E;
  assign div_zero = funct3E[2] && (rdata2E == 32'd0);
  assign div_ovf  = funct3E[2] && !funct3E[0] &&
                    (rdata1E == 32'h8000_0000) && (rdata2E == 32'hFFFF_FFFF);
  always_comb begin
    spec_val = 32'd0;
    if (div_zero)     spec_val = funct3E[1] ? rdata1E : 32'hFFFF_FFFF;
    else if (div_ovf) spec_val = funct3E[1] ? 32'd0 : 32'h8000_0000;
  end

  // One radix-2 step of each algorithm
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [33:0] div_trial;
  assign mul_sum   = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, a_q} : 33'd0);
  assign div_shift = {rem_q[31:0], quo_q[31]};
  assign div_trial = {1'b0, div_shift} - {2'b00, b_q};

  // Sign fix-up applied while in DONE
  logic [63:0] prod_s;
  logic [31:0] quo_s, rem_s, final_res;
  assign prod_s = neg_q ? (64'd0 - prod_q) : prod_q;
  assign quo_s  = neg_q ? (32'd0 - quo_q) : quo_q;
  assign rem_s  = rem_neg_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
  always_comb begin
    final_res = 32'd0;
    if (special_q) final_res = spec_res_q;
    else begin
      case (op_q)
        3'b000:               final_res = prod_s[31:0];
        3'b001, 3'b010, 3'b011: final_res = prod_s[63:32];
        3'b100, 3'b101:       final_res = quo_s;
        default:              final_res = rem_s;
      endcase
    end
  end

  // Handshake: an op is accepted on an edge where state is IDLE, start=1 and
  // flush=0; stall holds the upstream stages until DONE, where done pulses with
  // result valid and the pipeline advances on that cycle's closing edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    prod_d     = prod_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    special_d  = special_q;
    spec_res_d = spec_res_q;
    result_d   = result_q;
    stall      = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          stall      = 1'b1;
          op_d       = funct3E;
          a_d        = a_mag;
          b_d        = b_mag;
          prod_d     = {32'd0, b_mag};
          quo_d      = a_mag;
          rem_d      = 33'd0;
          neg_d      = a_neg ^ b_neg;
          rem_neg_d  = a_neg;
          special_d  = div_zero | div_ovf;
          spec_res_d = spec_val;
          cnt_d      = 5'd0;
          state_d    = (div_zero | div_ovf) ? DONE : CALC;
        end
      end
      CALC: begin
        stall = 1'b1;
        if (flush) state_d = IDLE;
        else begin
          if (op_q[2]) begin
            if (!div_trial[33]) begin
              rem_d = div_trial[32:0];
              quo_d = {quo_q[30:0], 1'b1};
            end else begin
              rem_d = div_shift;
              quo_d = {quo_q[30:0], 1'b0};
            end
          end else begin
            prod_d = {mul_sum, prod_q[31:1]};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!flush) begin
          done     = 1'b1;
          result_d = final_res;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst) stall = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      op_q       <= 3'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      prod_q     <= 64'd0;
      quo_q      <= 32'd0;
      rem_q      <= 33'd0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      special_q  <= 1'b0;
      spec_res_q <= 32'd0;
      result_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      prod_q     <= prod_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      special_q  <= special_d;
      spec_res_q <= spec_res_d;
      result_q   <= result_d;
    end
  end

  // Remainder stays below the divisor, so its top bit never feeds the result
  logic unused_bits;
  assign unused_bits = rem_q[32];

  assign busy      = (state_q != IDLE);
  assign result    = done ? final_res : result_q;
  assign dbg_state = state_q;

endmodule
